fb_ddram_arbiter: RTL
=====================

# fb_ddram_arbiter

Shares the single `DDRAM_*` master port in the `CLK_VIDEO` domain between two requesters:
- a posted write stream from the framebuffer rotator, which issues one 64-bit beat per pixel and ignores backpressure;
- a burst-read client, such as a framebuffer readback or overlay fetcher.

Rotator writes are absorbed in an internal FIFO. An arbitration FSM then sequences Avalon-style commands onto DDRAM, holding each command until `DDRAM_BUSY` is low. The block sits between the rotator/reader and the top-level DDRAM port.

## Interface
- `FIFO_DEPTH`, 16: write FIFO entries; power of two, at least 4.
- `CLK_VIDEO` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_req` in 1: push one write beat this cycle.
- `wr_addr` in 29: beat address, in 64-bit words.
- `wr_din` in 64: write data.
- `wr_be` in 8: byte enables.
- `wr_ovf` out 1: sticky flag, set when a beat is dropped.
- `rd_req` in 1: read request; sampled only while `rd_busy`=0.
- `rd_addr` in 29: read start address.
- `rd_burstcnt` in 8: beats to read; 0 is treated as 1.
- `rd_busy` out 1: a read is accepted and not yet complete.
- `rd_dout` out 64: returned read data.
- `rd_dout_ready` out 1: `rd_dout` is valid this cycle.
- `DDRAM_BUSY` in 1: DDRAM is stalling the current command.
- `DDRAM_BURSTCNT` out 8: burst length of the current command.
- `DDRAM_ADDR` out 29: command address.
- `DDRAM_DIN` out 64: write data.
- `DDRAM_BE` out 8: write byte enables.
- `DDRAM_WE` out 1: write command strobe.
- `DDRAM_RD` out 1: read command strobe.
- `DDRAM_DOUT` in 64: read data from DDRAM.
- `DDRAM_DOUT_READY` in 1: `DDRAM_DOUT` is valid this cycle.

## Operation
- **Write FIFO:** each entry holds `{addr, din, be}`.
  - `wr_req`=1 pushes the entry unless the FIFO is full with no pop on the same edge.
  - A push that is rejected drops the beat and sets `wr_ovf`. `wr_ovf` clears only on reset.
  - A push and a pop on the same edge while full are both accepted; the count is unchanged.
- **Urgent condition:** FIFO count ≥ `FIFO_DEPTH`/2.
- **Read capture:** `rd_req`=1 while `rd_busy`=0 latches `rd_addr` and the burst length (0 forced to 1), and sets `rd_busy`.
- **FSM states:** IDLE, WRITE, RD_ISSUE, RD_WAIT.
- **IDLE:**
  - If a read is pending and the FIFO is not urgent, go to RD_ISSUE.
  - Otherwise, if the FIFO is non-empty, go to WRITE.
  - Otherwise, if a read is pending, go to RD_ISSUE.
- **WRITE:**
  - Drive `DDRAM_WE`=1 with the FIFO head, `DDRAM_BURSTCNT`=1.
  - The command is accepted at an edge where `DDRAM_WE`=1 and `DDRAM_BUSY`=0; that edge pops the FIFO.
  - On accept, present the next entry without a gap if two or more entries remain and the condition "read pending and not urgent" is false.
  - Otherwise, on accept, return to IDLE.
- **RD_ISSUE:**
  - Drive `DDRAM_RD`=1 with the latched address and burst length.
  - On accept, go to RD_WAIT and load the beat counter.
- **RD_WAIT:**
  - Each `DDRAM_DOUT_READY` beat is forwarded as `rd_dout` / `rd_dout_ready`, registered one cycle later.
  - After the last beat, return to IDLE and clear `rd_busy`.
  - No write is issued during RD_WAIT; FIFO pushes continue.
- **Stray data:** `DDRAM_DOUT_READY` outside RD_WAIT is ignored.
- **Command stability:** while `DDRAM_BUSY`=1, all `DDRAM_*` command outputs hold their values.
- **Reset:** asserting `reset_n` mid-operation aborts any burst, empties the FIFO and returns the FSM to IDLE. In-flight read data arriving after reset is ignored.

## Timing
- **Reset values:**
  - `DDRAM_WE`, `DDRAM_RD` = 0.
  - `DDRAM_ADDR`, `DDRAM_DIN`, `DDRAM_BE` = 0.
  - `DDRAM_BURSTCNT` = 1.
  - `rd_busy`, `rd_dout_ready`, `wr_ovf` = 0.
  - `rd_dout` = 0.
- All outputs are registered.
- **Write latency:** `wr_req` at edge N into an empty FIFO with the FSM idle gives `DDRAM_WE`=1 after edge N+1.
- **Write throughput:** sustained writes run at 1 beat/cycle while `DDRAM_BUSY`=0.
- **Read latency:** `rd_req` at edge N with the FSM idle gives `rd_busy`=1 after edge N and `DDRAM_RD`=1 after edge N+1.
- **Read data:** `rd_dout_ready` follows `DDRAM_DOUT_READY` by exactly 1 cycle.
- **Read completion:** `rd_busy` falls on the same edge that raises the final `rd_dout_ready`.
- **Arbitration decisions** take effect one edge after they are made; RD_WAIT → IDLE → next command costs one idle cycle.

## Test plan
- **Single write:** reset, then one write with addr 0x0012345, din 0xA5A5…, be 0x0F, `DDRAM_BUSY`=0 → one `DDRAM_WE` pulse after edge N+1 with matching addr/din/be, `BURSTCNT`=1.
- **Backpressure:** 20 consecutive `wr_req` with `DDRAM_BUSY` held high → first 16 queued, `wr_ovf`=1 on the 17th. Releasing BUSY drains exactly 16 beats in order, back-to-back; `DDRAM_WE` holds stable while BUSY.
- **Read burst:** `rd_req` addr 0x100, burstcnt 4; DDRAM returns 4 beats with gaps → 4 `rd_dout_ready` pulses, each 1 cycle after the source beat. `rd_busy` falls with the 4th. `rd_burstcnt`=0 → exactly 1 beat.
- **Arbitration:** FIFO holds 3 entries and a read is pending → read is issued first, writes resume after the burst. With the FIFO at 8 entries and a read pending → writes drain to 7 before `DDRAM_RD` is issued.
- **Reset mid-operation:** `reset_n` low during RD_WAIT of a burst-8 read and with 5 FIFO entries → all outputs at reset values. Later `DDRAM_DOUT_READY` pulses produce no `rd_dout_ready`; FIFO is empty afterwards.

Source files
------------

// File: rtl/fb_ddram_arbiter.sv
// Arbitrates the CLK_VIDEO DDRAM master port between a posted rotator write
// stream, buffered in a FIFO, and a single outstanding burst-read client.
module fb_ddram_arbiter #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        CLK_VIDEO,
    input  logic        reset_n,

    input  logic        wr_req,
    input  logic [28:0] wr_addr,
    input  logic [63:0] wr_din,
    input  logic [7:0]  wr_be,
    output logic        wr_ovf,

    input  logic        rd_req,
    input  logic [28:0] rd_addr,
    input  logic [7:0]  rd_burstcnt,
    output logic        rd_busy,
    output logic [63:0] rd_dout,
    output logic        rd_dout_ready,

    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_TWO  = {{(AW-1){1'b0}}, 2'b10};
    localparam logic [AW:0]   CNT_HALF = {2'b01, {(AW-1){1'b0}}};
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_t;
    state_t state;

    logic [28:0] fifo_addr [FIFO_DEPTH];
    logic [63:0] fifo_din  [FIFO_DEPTH];
    logic [7:0]  fifo_be   [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr, head_nxt;
    logic [AW:0]   count, count_next;

    logic        wr_accept, full, push, urgent, rd_first;
    logic        rd_pend;
    logic [28:0] rd_addr_q;
    logic [7:0]  rd_len, beats_left;

    // Urgency is judged on the occupancy that will exist after this edge,
    // so the write that takes the FIFO below half-full hands over to a read.
    always_comb begin
        wr_accept  = DDRAM_WE && !DDRAM_BUSY;
        full       = (count == CNT_FULL);
        push       = wr_req && (!full || wr_accept);
        count_next = count;
        if (push && !wr_accept)
            count_next = count + CNT_ONE;
        else if (!push && wr_accept)
            count_next = count - CNT_ONE;
        urgent   = (count_next >= CNT_HALF);
        rd_first = rd_pend && !urgent;
        head_nxt = rptr + PTR_ONE;
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (push) begin
            fifo_addr[wptr] <= wr_addr;
            fifo_din[wptr]  <= wr_din;
            fifo_be[wptr]   <= wr_be;
        end
    end

    always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
        if (!reset_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            wr_ovf <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PTR_ONE;
            if (wr_accept)
                rptr <= head_nxt;
            count <= count_next;
            if (wr_req && !push)
                wr_ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            DDRAM_WE       <= 1'b0;
            DDRAM_RD       <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_BE       <= '0;
            DDRAM_BURSTCNT <= 8'd1;
            rd_busy        <= 1'b0;
            rd_pend        <= 1'b0;
            rd_addr_q      <= '0;
            rd_len         <= 8'd1;
            beats_left     <= '0;
            rd_dout        <= '0;
            rd_dout_ready  <= 1'b0;
        end else begin
            rd_dout_ready <= 1'b0;
            if (state == RD_WAIT && DDRAM_DOUT_READY) begin
                rd_dout       <= DDRAM_DOUT;
                rd_dout_ready <= 1'b1;
            end

            if (rd_req && !rd_busy) begin
                rd_busy   <= 1'b1;
                rd_pend   <= 1'b1;
                rd_addr_q <= rd_addr;
                rd_len    <= (rd_burstcnt == '0) ? 8'd1 : rd_burstcnt;
            end

            case (state)
                IDLE: begin
                    if (rd_pend && (!urgent || count == '0)) begin
                        state          <= RD_ISSUE;
                        DDRAM_RD       <= 1'b1;
                        DDRAM_ADDR     <= rd_addr_q;
                        DDRAM_BURSTCNT <= rd_len;
                    end else if (count != '0) begin
                        state          <= WRITE;
                        DDRAM_WE       <= 1'b1;
                        DDRAM_ADDR     <= fifo_addr[rptr];
                        DDRAM_DIN      <= fifo_din[rptr];
                        DDRAM_BE       <= fifo_be[rptr];
                        DDRAM_BURSTCNT <= 8'd1;
                    end
                end
                WRITE: begin
                    if (!DDRAM_BUSY) begin
                        if (count >= CNT_TWO && !rd_first) begin
                            DDRAM_ADDR <= fifo_addr[head_nxt];
                            DDRAM_DIN  <= fifo_din[head_nxt];
                            DDRAM_BE   <= fifo_be[head_nxt];
                        end else begin
                            DDRAM_WE <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD   <= 1'b0;
                        rd_pend    <= 1'b0;
                        beats_left <= DDRAM_BURSTCNT;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        beats_left <= beats_left - 8'd1;
                        if (beats_left == 8'd1) begin
                            rd_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
